// File: rtl/axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo
//
// Single-clock AXI4-Stream FIFO with first-word-fall-through output. Words
// are kept in a circular buffer addressed by a write pointer and a read
// pointer. A separate level counter tracks how many words are stored. Each
// word is stored together with its tuser and tlast sideband bits.
//
// Parameters
//   DATA_BYTES : tdata width in bytes (tdata is 8*DATA_BYTES bits), >= 1
//   DEPTH      : number of storage entries, >= 2, any value (not only 2^n)
//   AF_THRESH  : almost_full  asserts when level >= AF_THRESH (1..DEPTH)
//   AE_THRESH  : almost_empty asserts when level <= AE_THRESH (0..DEPTH-1)
//
// Ports
//   aclk           in   rising-edge clock for all state
//   rst            in   synchronous, active-high reset
//   s_axis_tdata   in   write data
//   s_axis_tvalid  in   write request
//   s_axis_tready  out  FIFO can accept a word (level != DEPTH)
//   s_axis_tuser   in   sideband bit, stored with the word
//   s_axis_tlast   in   packet end, stored with the word
//   m_axis_tdata   out  head-of-queue data (only meaningful while tvalid=1)
//   m_axis_tvalid  out  a head word is present (level != 0)
//   m_axis_tready  in   consumer accepts the head word
//   m_axis_tuser   out  sideband of the head word
//   m_axis_tlast   out  packet end of the head word
//   level          out  number of stored words, 0..DEPTH
//   almost_full    out  level >= AF_THRESH
//   almost_empty   out  level <= AE_THRESH
// -----------------------------------------------------------------------------
module axis_sync_fifo #(
  parameter int DATA_BYTES = 2,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1,
  localparam int LW        = $clog2(DEPTH + 1)
) (
  input  logic                    aclk,
  input  logic                    rst,

  input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,

  output logic [8*DATA_BYTES-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,

  output logic [LW-1:0]           level,
  output logic                    almost_full,
  output logic                    almost_empty
);

  localparam int DW = 8 * DATA_BYTES;
  // Pointer width: enough to address entries 0..DEPTH-1 (DEPTH >= 2, so >= 1).
  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF    = LW'(AF_THRESH);
  localparam logic [LW-1:0] LVL_AE    = LW'(AE_THRESH);

  // One storage entry: data plus the sideband that must travel with it.
  typedef struct packed {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q,  level_d;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // Both ready and valid come only from the registered level. This keeps
  // m_axis_tready out of the s_axis_tready path. As a consequence, a full
  // FIFO refuses a write even in a cycle where it is also being read.
  logic wr_fire;
  logic rd_fire;
  entry_t wr_entry;
  entry_t head_entry;

  assign s_axis_tready = (level_q != LVL_FULL);
  assign m_axis_tvalid = (level_q != '0);

  // During reset the whole transfer is discarded, so no storage write occurs
  // and no pointer moves.
  assign wr_fire = s_axis_tvalid & s_axis_tready & ~rst;
  assign rd_fire = m_axis_tvalid & m_axis_tready & ~rst;

  assign wr_entry = '{data: s_axis_tdata, user: s_axis_tuser, last: s_axis_tlast};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each always_comb assigns defaults first, so every path drives every
  // output and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    // The pointers wrap explicitly at DEPTH-1. This keeps the buffer correct
    // when DEPTH is not a power of two.
    if (wr_fire) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end

    // The level is unchanged when both transfers happen or when neither does.
    unique case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge.
  always_ff @(posedge aclk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array has no reset. Stale entries are never visible,
  // because m_axis_tvalid depends only on the level, and the level is cleared.
  always_ff @(posedge aclk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // First-word-fall-through: the head entry is read combinationally from the
  // registered read pointer. A word written at edge N becomes visible after
  // edge N, and there is no same-cycle bypass. The head stays stable while the
  // consumer stalls, because rd_ptr_q moves only on a read transfer.
  assign head_entry   = mem_q[rd_ptr_q];
  assign m_axis_tdata = head_entry.data;
  assign m_axis_tuser = head_entry.user;
  assign m_axis_tlast = head_entry.last;

  assign level        = level_q;
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);

endmodule

// File: tb/tb_axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_sync_fifo
//
// Directed bench for axis_sync_fifo with DATA_BYTES=2, DEPTH=4, AF_THRESH=3
// and AE_THRESH=1. Each step drives inputs 1 ns after a rising edge and
// samples outputs 1 ns after the next rising edge. Every expected value is a
// hand-computed constant.
// -----------------------------------------------------------------------------
module tb_axis_sync_fifo;

  localparam int DATA_BYTES = 2;
  localparam int DEPTH      = 4;
  localparam int AF_THRESH  = 3;
  localparam int AE_THRESH  = 1;
  localparam int LW         = $clog2(DEPTH + 1);

  logic          aclk;
  logic          rst;
  logic [15:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tuser;
  logic          s_axis_tlast;
  logic [15:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          almost_empty;

  int pass_cnt  = 0;
  int check_cnt = 0;

  axis_sync_fifo #(
    .DATA_BYTES (DATA_BYTES),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF_THRESH),
    .AE_THRESH  (AE_THRESH)
  ) dut (
    .aclk          (aclk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .level         (level),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock and land 1 ns after the rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_wr(input logic v, input logic [15:0] d, input logic u, input logic l);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
  endtask

  initial begin
    rst           = 1'b1;
    m_axis_tready = 1'b0;
    drive_wr(1'b0, 16'h0000, 1'b0, 1'b0);

    // ---------------- Reset state ----------------
    tick();
    tick();
    check("rst_s_tready", 32'(s_axis_tready), 32'd1);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_level",    32'(level),         32'd0);
    rst = 1'b0;
    tick();
    check("idle_level",   32'(level),         32'd0);
    check("idle_ae",      32'(almost_empty),  32'd1);
    check("idle_af",      32'(almost_full),   32'd0);

    // ---------------- Fill ----------------
    m_axis_tready = 1'b0;
    drive_wr(1'b1, 16'h1111, 1'b0, 1'b0);
    tick();
    check("fill1_level",  32'(level),         32'd1);
    check("fill1_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("fill1_head",   32'(m_axis_tdata),  32'h1111);
    check("fill1_ae",     32'(almost_empty),  32'd1);
    check("fill1_af",     32'(almost_full),   32'd0);
    drive_wr(1'b1, 16'h2222, 1'b0, 1'b0);
    tick();
    check("fill2_level",  32'(level),         32'd2);
    check("fill2_ae",     32'(almost_empty),  32'd0);
    check("fill2_af",     32'(almost_full),   32'd0);
    drive_wr(1'b1, 16'h3333, 1'b0, 1'b0);
    tick();
    check("fill3_level",  32'(level),         32'd3);
    check("fill3_af",     32'(almost_full),   32'd1);
    check("fill3_tready", 32'(s_axis_tready), 32'd1);
    drive_wr(1'b1, 16'h4444, 1'b0, 1'b0);
    tick();
    check("fill4_level",  32'(level),         32'd4);
    check("fill4_tready", 32'(s_axis_tready), 32'd0);
    drive_wr(1'b1, 16'h5555, 1'b0, 1'b0);
    tick();
    check("fill5_level",  32'(level),         32'd4);
    check("fill5_head",   32'(m_axis_tdata),  32'h1111);
    drive_wr(1'b0, 16'h0000, 1'b0, 1'b0);

    // ---------------- Drain ----------------
    m_axis_tready = 1'b1;
    check("drain_head0",  32'(m_axis_tdata),  32'h1111);
    tick();
    check("drain_lvl0",   32'(level),         32'd3);
    check("drain_head1",  32'(m_axis_tdata),  32'h2222);
    tick();
    check("drain_lvl1",   32'(level),         32'd2);
    check("drain_head2",  32'(m_axis_tdata),  32'h3333);
    tick();
    check("drain_lvl2",   32'(level),         32'd1);
    check("drain_ae2",    32'(almost_empty),  32'd1);
    check("drain_head3",  32'(m_axis_tdata),  32'h4444);
    tick();
    check("drain_level",  32'(level),         32'd0);
    check("drain_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("drain_ae",     32'(almost_empty),  32'd1);
    check("drain_tready", 32'(s_axis_tready), 32'd1);

    // ---------------- Wrap with simultaneous read and write ----------------
    m_axis_tready = 1'b0;
    drive_wr(1'b1, 16'h0100, 1'b0, 1'b0);
    tick();
    drive_wr(1'b1, 16'h0101, 1'b0, 1'b0);
    tick();
    check("wrap_pre_lvl", 32'(level),         32'd2);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_wr(1'b1, 16'h0102 + 16'(i), 1'b0, 1'b0);
      #1;
      check($sformatf("wrap_head%0d", i), 32'(m_axis_tdata), 32'h0100 + 32'(i));
      tick();
      check($sformatf("wrap_lvl%0d", i),  32'(level),        32'd2);
    end
    drive_wr(1'b0, 16'h0000, 1'b0, 1'b0);
    check("wrap_tail0",   32'(m_axis_tdata),  32'h010A);
    tick();
    check("wrap_tail1",   32'(m_axis_tdata),  32'h010B);
    tick();
    check("wrap_empty",   32'(m_axis_tvalid), 32'd0);

    // ---------------- Full plus read ----------------
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_wr(1'b1, 16'hA001 + 16'(i), 1'b0, 1'b0);
      tick();
    end
    check("fr_full_lvl",  32'(level),         32'd4);
    drive_wr(1'b1, 16'hAAAA, 1'b0, 1'b0);
    m_axis_tready = 1'b1;
    #1;
    check("fr_tready0",   32'(s_axis_tready), 32'd0);
    tick();
    check("fr_lvl3",      32'(level),         32'd3);
    check("fr_head",      32'(m_axis_tdata),  32'hA002);
    check("fr_tready1",   32'(s_axis_tready), 32'd1);
    m_axis_tready = 1'b0;
    tick();
    check("fr_lvl4",      32'(level),         32'd4);
    drive_wr(1'b0, 16'h0000, 1'b0, 1'b0);
    m_axis_tready = 1'b1;
    check("fr_out0",      32'(m_axis_tdata),  32'hA002);
    tick();
    check("fr_out1",      32'(m_axis_tdata),  32'hA003);
    tick();
    check("fr_out2",      32'(m_axis_tdata),  32'hA004);
    tick();
    check("fr_out3",      32'(m_axis_tdata),  32'hAAAA);
    tick();
    check("fr_empty",     32'(level),         32'd0);

    // ---------------- Sideband ----------------
    m_axis_tready = 1'b0;
    drive_wr(1'b1, 16'h0001, 1'b1, 1'b0);
    tick();
    drive_wr(1'b1, 16'h0002, 1'b0, 1'b1);
    tick();
    drive_wr(1'b0, 16'h0000, 1'b0, 1'b0);
    check("sb0_data",     32'(m_axis_tdata),  32'h0001);
    check("sb0_user",     32'(m_axis_tuser),  32'd1);
    check("sb0_last",     32'(m_axis_tlast),  32'd0);
    m_axis_tready = 1'b1;
    tick();
    check("sb1_data",     32'(m_axis_tdata),  32'h0002);
    check("sb1_user",     32'(m_axis_tuser),  32'd0);
    check("sb1_last",     32'(m_axis_tlast),  32'd1);
    tick();
    check("sb_empty",     32'(m_axis_tvalid), 32'd0);

    // ---------------- Reset during traffic ----------------
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_wr(1'b1, 16'hC001 + 16'(i), 1'b0, 1'b0);
      tick();
    end
    check("mr_pre_lvl",   32'(level),         32'd3);
    rst = 1'b1;
    drive_wr(1'b1, 16'hDEAD, 1'b0, 1'b0);
    m_axis_tready = 1'b1;
    tick();
    check("mr_level",     32'(level),         32'd0);
    check("mr_tvalid",    32'(m_axis_tvalid), 32'd0);
    check("mr_tready",    32'(s_axis_tready), 32'd1);
    rst = 1'b0;
    m_axis_tready = 1'b0;
    drive_wr(1'b1, 16'hBEEF, 1'b0, 1'b0);
    tick();
    drive_wr(1'b0, 16'h0000, 1'b0, 1'b0);
    check("mr_post_tv",   32'(m_axis_tvalid), 32'd1);
    check("mr_post_data", 32'(m_axis_tdata),  32'hBEEF);
    check("mr_post_lvl",  32'(level),         32'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
